// File: rtl/axi_stream_downsizer.sv
// rtl/axi_stream_downsizer.sv - serialises a packed wide AXI-stream into narrow words
// Bytes past the first clear tkeep bit are zeroed on entry so remainders never carry stale data.
module axi_stream_downsizer #(
  parameter int IEW = 2,
  parameter int OEW = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  i_tready,
  input  logic                  i_tvalid,
  input  logic [(8<<IEW)-1:0]   i_tdata,
  input  logic [(1<<IEW)-1:0]   i_tkeep,
  input  logic                  i_tlast,
  input  logic                  o_tready,
  output logic                  o_tvalid,
  output logic [(8<<OEW)-1:0]   o_tdata,
  output logic [(1<<OEW)-1:0]   o_tkeep,
  output logic                  o_tlast
);

  localparam int IB = 1 << IEW;
  localparam int OB = 1 << OEW;
  localparam int IW = 8 * IB;
  localparam int OW = 8 * OB;
  localparam logic [IEW:0] OB_N = (IEW + 1)'(OB);

  if (IEW < OEW || IEW > 6) begin : g_bad_params
    $error("axi_stream_downsizer: IEW must be in OEW..6");
  end

  logic [IW-1:0] r_bytes_q, r_bytes_d;
  logic [IEW:0]  r_count_q, r_count_d;
  logic          r_last_q, r_last_d;
  logic          o_tvalid_q, o_tvalid_d;
  logic [OW-1:0] o_tdata_q, o_tdata_d;
  logic [OB-1:0] o_tkeep_q, o_tkeep_d;
  logic          o_tlast_q, o_tlast_d;

  logic          slot;
  logic [IEW:0]  n;
  logic [IW-1:0] in_bytes;
  logic [IW-1:0] in_shift;
  logic [IW-1:0] r_shift;

  function automatic logic [OB-1:0] keep_mask(input logic [IEW:0] c);
    logic [OB-1:0] m;
    for (int k = 0; k < OB; k++) m[k] = ((IEW + 1)'(k) < c);
    return m;
  endfunction

  function automatic logic [IEW:0] min_ob(input logic [IEW:0] c);
    return (c > OB_N) ? OB_N : c;
  endfunction

  always_comb begin
    logic run;
    n   = '0;
    run = 1'b1;
    for (int k = 0; k < IB; k++) begin
      if (run && i_tkeep[k]) n = n + 1'b1;
      else run = 1'b0;
    end
  end

  always_comb begin
    in_bytes = '0;
    for (int k = 0; k < IB; k++)
      in_bytes[8*k +: 8] = ((IEW + 1)'(k) < n) ? i_tdata[8*k +: 8] : 8'h00;
  end

  if (IEW > OEW) begin : g_shift
    assign in_shift = {{OW{1'b0}}, in_bytes[IW-1:OW]};
    assign r_shift  = {{OW{1'b0}}, r_bytes_q[IW-1:OW]};
  end else begin : g_no_shift
    assign in_shift = '0;
    assign r_shift  = '0;
  end

  assign slot     = o_tready | ~o_tvalid_q;
  assign i_tready = slot & (r_count_q == '0);

  // Remainder words take precedence; a new beat is only taken once the remainder is drained.
  always_comb begin
    r_bytes_d  = r_bytes_q;
    r_count_d  = r_count_q;
    r_last_d   = r_last_q;
    o_tvalid_d = o_tvalid_q;
    o_tdata_d  = o_tdata_q;
    o_tkeep_d  = o_tkeep_q;
    o_tlast_d  = o_tlast_q;
    if (o_tready) o_tvalid_d = 1'b0;
    if (slot && r_count_q != '0) begin
      o_tvalid_d = 1'b1;
      o_tdata_d  = r_bytes_q[OW-1:0];
      o_tkeep_d  = keep_mask(r_count_q);
      o_tlast_d  = r_last_q & (r_count_q <= OB_N);
      r_count_d  = r_count_q - min_ob(r_count_q);
      r_bytes_d  = r_shift;
    end else if (slot && i_tvalid) begin
      o_tvalid_d = (n != '0) | i_tlast;
      o_tdata_d  = in_bytes[OW-1:0];
      o_tkeep_d  = keep_mask(n);
      o_tlast_d  = i_tlast & (n <= OB_N);
      r_count_d  = n - min_ob(n);
      r_bytes_d  = in_shift;
      r_last_d   = i_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bytes_q  <= '0;
      r_count_q  <= '0;
      r_last_q   <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tkeep_q  <= '0;
      o_tlast_q  <= 1'b0;
    end else begin
      r_bytes_q  <= r_bytes_d;
      r_count_q  <= r_count_d;
      r_last_q   <= r_last_d;
      o_tvalid_q <= o_tvalid_d;
      o_tdata_q  <= o_tdata_d;
      o_tkeep_q  <= o_tkeep_d;
      o_tlast_q  <= o_tlast_d;
    end
  end

  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign o_tkeep  = o_tkeep_q;
  assign o_tlast  = o_tlast_q;

endmodule

// File: tb/tb_axi_stream_downsizer.sv
// tb/tb_axi_stream_downsizer.sv - directed bench for the 32-to-8 downsizer and a 32-bit slice
module tb_axi_stream_downsizer;

  logic        clk = 1'b0;
  logic        rstn;

  logic        i_tready, i_tvalid, i_tlast, o_tready, o_tvalid, o_tlast;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic [7:0]  o_tdata;
  logic [0:0]  o_tkeep;

  logic        p_i_tready, p_i_tvalid, p_i_tlast, p_o_tready, p_o_tvalid, p_o_tlast;
  logic [31:0] p_i_tdata, p_o_tdata;
  logic [3:0]  p_i_tkeep, p_o_tkeep;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_stream_downsizer #(.IEW(2), .OEW(0)) u_dut (
    .clk(clk), .rstn(rstn),
    .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
    .i_tkeep(i_tkeep), .i_tlast(i_tlast),
    .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata),
    .o_tkeep(o_tkeep), .o_tlast(o_tlast)
  );

  axi_stream_downsizer #(.IEW(2), .OEW(2)) u_pass (
    .clk(clk), .rstn(rstn),
    .i_tready(p_i_tready), .i_tvalid(p_i_tvalid), .i_tdata(p_i_tdata),
    .i_tkeep(p_i_tkeep), .i_tlast(p_i_tlast),
    .o_tready(p_o_tready), .o_tvalid(p_o_tvalid), .o_tdata(p_o_tdata),
    .o_tkeep(p_o_tkeep), .o_tlast(p_o_tlast)
  );

  // {o_tvalid, o_tdata, o_tkeep, o_tlast, i_tready}
  wire [11:0] obs = {o_tvalid, o_tdata, o_tkeep, o_tlast, i_tready};

  task automatic test_reset;
    rstn = 1'b0;
    i_tvalid = 1'b0; i_tdata = '0; i_tkeep = '0; i_tlast = 1'b0; o_tready = 1'b1;
    p_i_tvalid = 1'b0; p_i_tdata = '0; p_i_tkeep = '0; p_i_tlast = 1'b0; p_o_tready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 12'b0_00000000_0_0_1) begin
      $display("FAIL reset_state obs=%h exp=%h", obs, 12'b0_00000000_0_0_1); n_fail++;
    end
    n_checks++;
    if ({p_o_tvalid, p_o_tdata, p_o_tkeep, p_o_tlast, p_i_tready} !== {1'b0, 32'h0, 4'h0, 1'b0, 1'b1}) begin
      $display("FAIL reset_pass v=%b d=%h k=%h l=%b rdy=%b", p_o_tvalid, p_o_tdata, p_o_tkeep, p_o_tlast, p_i_tready);
      n_fail++;
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_beat;
    logic [11:0] exp [4];
    exp = '{{1'b1, 8'h11, 1'b1, 1'b0, 1'b0}, {1'b1, 8'h22, 1'b1, 1'b0, 1'b0},
            {1'b1, 8'h33, 1'b1, 1'b0, 1'b0}, {1'b1, 8'h44, 1'b1, 1'b1, 1'b1}};
    i_tvalid = 1'b1; i_tdata = 32'h44332211; i_tkeep = 4'b1111; i_tlast = 1'b1; o_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_tvalid = 1'b0;
      n_checks++;
      if (obs !== exp[i]) begin
        $display("FAIL full_beat_word%0d obs=%h exp=%h", i, obs, exp[i]); n_fail++;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({o_tvalid, i_tready} !== 2'b01) begin
      $display("FAIL full_beat_idle v/rdy=%b exp=01", {o_tvalid, i_tready}); n_fail++;
    end
  endtask

  task automatic test_partial_beat;
    logic [11:0] exp [6];
    exp = '{{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0}, {1'b1, 8'hBB, 1'b1, 1'b0, 1'b1},
            {1'b1, 8'h01, 1'b1, 1'b0, 1'b0}, {1'b1, 8'h02, 1'b1, 1'b0, 1'b0},
            {1'b1, 8'h03, 1'b1, 1'b0, 1'b0}, {1'b1, 8'h04, 1'b1, 1'b1, 1'b1}};
    i_tvalid = 1'b1; i_tdata = 32'hDEADBBAA; i_tkeep = 4'b0011; i_tlast = 1'b0; o_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin i_tdata = 32'h04030201; i_tkeep = 4'b1111; i_tlast = 1'b1; end
      if (i == 2) i_tvalid = 1'b0;
      n_checks++;
      if (obs !== exp[i]) begin
        $display("FAIL partial_word%0d obs=%h exp=%h", i, obs, exp[i]); n_fail++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (o_tvalid !== 1'b0) begin
      $display("FAIL partial_idle o_tvalid=%b exp=0", o_tvalid); n_fail++;
    end
  endtask

  task automatic test_backpressure;
    logic       pat [8];
    logic [8:0] exp [7];
    logic [31:0] seq;
    int          n_hs;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp = '{{8'h11, 1'b0}, {8'h11, 1'b0}, {8'h11, 1'b0}, {8'h22, 1'b0},
            {8'h22, 1'b0}, {8'h33, 1'b0}, {8'h44, 1'b1}};
    seq = '0; n_hs = 0;
    for (int k = 0; k < 8; k++) begin
      if (k >= 1) begin
        i_tvalid = 1'b0;
        n_checks++;
        if ({o_tvalid, o_tdata, o_tlast} !== {1'b1, exp[k-1]}) begin
          $display("FAIL bp_cycle%0d v=%b d=%h l=%b exp_d=%h", k, o_tvalid, o_tdata, o_tlast, exp[k-1][8:1]);
          n_fail++;
        end
      end else begin
        i_tvalid = 1'b1; i_tdata = 32'h44332211; i_tkeep = 4'b1111; i_tlast = 1'b1;
      end
      o_tready = pat[k];
      if (o_tvalid && o_tready) begin
        seq = {o_tdata, seq[31:8]}; n_hs++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (o_tvalid !== 1'b0) begin
      $display("FAIL bp_idle o_tvalid=%b exp=0", o_tvalid); n_fail++;
    end
    n_checks++;
    if (n_hs != 4 || seq !== 32'h44332211) begin
      $display("FAIL bp_sequence count=%0d seq=%h exp count=4 seq=44332211", n_hs, seq); n_fail++;
    end
  endtask

  task automatic test_empty_beats;
    o_tready = 1'b1;
    i_tvalid = 1'b1; i_tdata = 32'hCAFEF00D; i_tkeep = 4'b0000; i_tlast = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      $display("FAIL empty_last obs=%h exp=%h", obs, {1'b1, 8'h00, 1'b0, 1'b1, 1'b1}); n_fail++;
    end
    i_tlast = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_tvalid, i_tready} !== 2'b01) begin
      $display("FAIL empty_nolast v/rdy=%b exp=01", {o_tvalid, i_tready}); n_fail++;
    end
    i_tdata = 32'h44332211; i_tkeep = 4'b0101; i_tlast = 1'b1;
    @(negedge clk);
    i_tvalid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 8'h11, 1'b1, 1'b1, 1'b1}) begin
      $display("FAIL gap_keep obs=%h exp=%h", obs, {1'b1, 8'h11, 1'b1, 1'b1, 1'b1}); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (o_tvalid !== 1'b0) begin
      $display("FAIL gap_keep_single o_tvalid=%b exp=0", o_tvalid); n_fail++;
    end
  endtask

  task automatic test_reset_mid_beat;
    int n_seen;
    o_tready = 1'b1;
    i_tvalid = 1'b1; i_tdata = 32'h44332211; i_tkeep = 4'b1111; i_tlast = 1'b1;
    @(negedge clk);
    i_tvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_tvalid, o_tdata} !== {1'b1, 8'h22}) begin
      $display("FAIL rst_pre v=%b d=%h exp v=1 d=22", o_tvalid, o_tdata); n_fail++;
    end
    rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 12'b0_00000000_0_0_1) begin
      $display("FAIL rst_mid obs=%h exp=%h", obs, 12'b0_00000000_0_0_1); n_fail++;
    end
    rstn = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_tvalid) n_seen++;
    end
    n_checks++;
    if (n_seen != 0) begin
      $display("FAIL rst_no_resume words=%0d exp=0", n_seen); n_fail++;
    end
  endtask

  task automatic test_back_to_back_passthrough;
    logic [31:0] dat [8];
    logic [3:0]  kp  [8];
    logic        lst [8];
    logic [31:0] m;
    dat = '{32'h03020100, 32'h13121110, 32'hFF222120, 32'hFFFF3130,
            32'hFFFFFF40, 32'h53525150, 32'h12345678, 32'h73727170};
    kp  = '{4'hF, 4'hF, 4'h7, 4'h3, 4'h1, 4'hF, 4'h0, 4'hF};
    lst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    p_o_tready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{kp[i-1][b]}};
        n_checks++;
        if ({p_o_tvalid, p_o_tdata & m, p_o_tkeep, p_o_tlast, p_i_tready} !==
            {1'b1, dat[i-1] & m, kp[i-1], lst[i-1], 1'b1}) begin
          $display("FAIL pass_beat%0d v=%b d=%h k=%h l=%b rdy=%b exp d=%h k=%h l=%b", i - 1,
                   p_o_tvalid, p_o_tdata, p_o_tkeep, p_o_tlast, p_i_tready, dat[i-1] & m, kp[i-1], lst[i-1]);
          n_fail++;
        end
      end
      if (i < 8) begin
        p_i_tvalid = 1'b1; p_i_tdata = dat[i]; p_i_tkeep = kp[i]; p_i_tlast = lst[i];
      end else begin
        p_i_tvalid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (p_o_tvalid !== 1'b0) begin
      $display("FAIL pass_idle o_tvalid=%b exp=0", p_o_tvalid); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_partial_beat();
    test_backpressure();
    test_empty_beats();
    test_reset_mid_beat();
    test_back_to_back_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_downsizer.md
Name: axi_stream_downsizer

Overview:
- Downstream neighbour of the AXI-stream packer on the USB-TX path.
- Takes a packed wide stream (1<<IEW bytes/beat, valid bytes contiguous from byte 0) and serialises it into a narrow stream (1<<OEW bytes/beat) toward the FTDI chip-width interface.
- Preserves byte order, tlast and partial-beat tkeep.
- Full output throughput: one narrow word per cycle when o_tready=1.

Parameters:
- IEW, default 2: input byte width is 1<<IEW; input bit width is 8<<IEW. Legal range 0..6.
- OEW, default 0: output byte width is 1<<OEW; output bit width is 8<<OEW. IEW>=OEW is required; IEW<OEW is illegal (elaboration error).

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset, sampled on rising edge of clk
- i_tready  out  1  input ready (combinational)
- i_tvalid  in  1  input valid
- i_tdata  in  8<<IEW  input data, byte k at bits [8k+7:8k]
- i_tkeep  in  1<<IEW  input byte enables, packed (ones from bit 0)
- i_tlast  in  1  input end of packet
- o_tready  in  1  output ready
- o_tvalid  out  1  output valid (registered)
- o_tdata  out  8<<OEW  output data (registered)
- o_tkeep  out  1<<OEW  output byte enables (registered)
- o_tlast  out  1  output end of packet (registered)

Behaviour:
- Definitions: OB = 1<<OEW bytes; R = 1<<(IEW-OEW) output words per input beat.
- Byte count: n = number of consecutive 1s in i_tkeep starting at bit 0. Range 0..1<<IEW, width IEW+1. Bytes at or beyond the first 0 in tkeep are discarded (e.g. keep=0101 gives n=1).
- Words per beat: W = ceil(n/OB). Word k (k=0..W-1) carries input bytes [k*OB, k*OB+OB-1] in order. Its tkeep is the low min(OB, n-k*OB) bits set. o_tlast = i_tlast on word W-1 only, 0 otherwise.
- Empty beats:
  - n=0, i_tlast=1: emit exactly one word, tkeep=0, tdata=0, tlast=1, so the packet boundary is preserved.
  - n=0, i_tlast=0: beat consumed, nothing emitted.
- Internal state:
  - r_bytes: remainder bytes, 8<<IEW bits, shifted down by OB bytes per emitted word.
  - r_count: remaining byte count, IEW+1 bits.
  - r_last: latched i_tlast.
- Output slot free: slot = o_tready | ~o_tvalid.
- Each clock, in priority order:
  1. rstn=0: o_tvalid=0, o_tdata=0, o_tkeep=0, o_tlast=0, r_count=0, r_bytes=0, r_last=0.
  2. else if o_tready=1: clear o_tvalid (may be overridden below in the same cycle).
  3. else if slot & r_count!=0: emit the next word from r_bytes, then r_count -= min(OB, r_count) and r_bytes >>= 8*OB. o_tlast = r_last & (r_count<=OB).
  4. else if slot & r_count==0 & i_tvalid: accept the beat and emit word 0 directly in the same edge. Load remainder: r_count = n - min(OB, n), r_bytes = input bytes >> 8*OB, r_last = i_tlast.
- Ready: i_tready = slot & (r_count==0). Combinational on o_tready, no combinational path from i_tvalid.
- Latency: beat accepted at edge t gives word 0 valid after edge t, word k after edge t+k given o_tready=1. i_tready is low for W-1 cycles per beat.
- Back-to-back beats with no bubble: a new beat is accepted in the same cycle the last word of the previous beat is accepted by the sink.
- Backpressure: while o_tvalid=1 & o_tready=0, o_tdata/o_tkeep/o_tlast are held stable and no state changes.
- IEW=OEW: register slice. W<=1; i_tready = o_tready|~o_tvalid; one beat per cycle. Bytes beyond the first tkeep 0 are still dropped (output tkeep re-packed).
- Reset mid-operation: any in-flight remainder and registered output word are dropped at the reset edge; no partial packet is resumed afterwards.
- Arithmetic: r_count never exceeds (1<<IEW)-OB. All shifts use constant OB. No variable-amount shift on the data path beyond n-derived tkeep.

Test Plan (IEW=2, OEW=0 unless stated):
1. Full beat: i_tdata=0x44332211, keep=1111, last=1, o_tready=1. Outputs 0x11,0x22,0x33,0x44 on 4 consecutive cycles, all keep=1, tlast=1 only on 0x44. i_tready=0 for 3 cycles, then 1.
2. Partial beat: keep=0011, data=0xDEADBBAA, last=0, followed immediately by keep=1111, data=0x04030201, last=1. Stream is AA,BB,01,02,03,04 with no bubble; tlast only on 04.
3. Backpressure: scenario 1 with o_tready pattern 1,0,0,1,0,1,1. Each word held stable while o_tready=0; exact sequence 11,22,33,44 delivered, none duplicated or lost.
4. Empty beats: keep=0000/last=1 gives one word keep=0, tlast=1. keep=0000/last=0 gives no output and i_tready back to 1 next cycle. keep=0101 gives a single word carrying byte 0.
5. Reset mid-beat: rstn=0 after the 0x22 word of scenario 1. Next edge: o_tvalid=0, i_tready=1; 0x33/0x44 never appear.
6. IEW=OEW=2: 8 back-to-back beats with o_tready=1 pass through one per cycle with 1-cycle latency, tkeep/tlast unchanged.
